// File: rtl/data_memory_sync_if.sv
// Load/store bus between the RV32 pipeline and the synchronous data memory.
// Master issues load/store requests; slave returns registered load results and fault pulses.
interface data_memory_sync_if #(
    parameter int XLEN = 32
);
    logic            read_enable;
    logic [2:0]      read_funct3;
    logic [XLEN-1:0] read_addr;
    logic            write_enable;
    logic [2:0]      write_funct3;
    logic [XLEN-1:0] write_addr;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;
    logic            read_valid;
    logic            load_fault;
    logic            store_fault;

    modport master (
        output read_enable, read_funct3, read_addr,
        output write_enable, write_funct3, write_addr, write_data,
        input  read_data, read_valid, load_fault, store_fault
    );

    modport slave (
        input  read_enable, read_funct3, read_addr,
        input  write_enable, write_funct3, write_addr, write_data,
        output read_data, read_valid, load_fault, store_fault
    );
endinterface

// File: rtl/data_memory_sync.sv
// Byte-addressed RV32 data memory: four byte-lane RAMs with registered read,
// write-first bypass on same-cycle overlap, funct3 size/sign decode and fault pulses.
module data_memory_sync #(
    parameter int XLEN        = 32,
    parameter int BYTE_SIZE   = 8,
    parameter int DEPTH_BYTES = 4096,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input logic               clk,
    input logic               rst,
    data_memory_sync_if.slave bus
);
    localparam int LANES = XLEN / BYTE_SIZE;
    localparam int ROWS  = DEPTH_BYTES / LANES;
    localparam int ROW_W = ADDR_W - 2;

    logic              st_fault;
    logic              st_ok;
    logic              ld_fault;
    logic              ld_take;
    logic [ROW_W-1:0]  w_row;
    logic [ROW_W-1:0]  r_row;
    logic [XLEN-1:0]   lane_word;
    logic [XLEN-1:0]   read_data_c;

    logic              read_valid_d, read_valid_q;
    logic              load_fault_d, load_fault_q;
    logic              store_fault_d, store_fault_q;
    logic              kill_d, kill_q;
    logic [2:0]        funct3_d, funct3_q;
    logic [1:0]        off_d, off_q;

    assign w_row = bus.write_addr[ADDR_W-1:2];
    assign r_row = bus.read_addr[ADDR_W-1:2];

    // Aligned accesses never straddle a word, so any nonzero bit above ADDR_W is out of range.
    always_comb begin
        st_fault = 1'b0;
        case (bus.write_funct3)
            3'b000:  st_fault = 1'b0;
            3'b001:  st_fault = bus.write_addr[0];
            3'b010:  st_fault = |bus.write_addr[1:0];
            default: st_fault = 1'b1;
        endcase
        st_fault = st_fault || (|bus.write_addr[XLEN-1:ADDR_W]);
        st_ok    = bus.write_enable && !st_fault && !rst;

        ld_fault = 1'b0;
        case (bus.read_funct3)
            3'b000, 3'b100: ld_fault = 1'b0;
            3'b001, 3'b101: ld_fault = bus.read_addr[0];
            3'b010:         ld_fault = |bus.read_addr[1:0];
            default:        ld_fault = 1'b1;
        endcase
        ld_fault = ld_fault || (|bus.read_addr[XLEN-1:ADDR_W]);
        ld_take  = bus.read_enable && !rst;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [BYTE_SIZE-1:0] mem [0:ROWS-1];
            logic [BYTE_SIZE-1:0] wbyte;
            logic                 lane_we;
            logic                 byp_d, byp_q;
            logic [BYTE_SIZE-1:0] wbyte_q;
            logic [BYTE_SIZE-1:0] rd_q;

            // Narrow stores replicate their low byte/half onto every lane they may hit.
            always_comb begin
                lane_we = 1'b0;
                wbyte   = bus.write_data[gi*BYTE_SIZE +: BYTE_SIZE];
                case (bus.write_funct3)
                    3'b000: begin
                        lane_we = (bus.write_addr[1:0] == LANE);
                        wbyte   = bus.write_data[BYTE_SIZE-1:0];
                    end
                    3'b001: begin
                        lane_we = (bus.write_addr[1] == LANE[1]);
                        wbyte   = bus.write_data[(gi%2)*BYTE_SIZE +: BYTE_SIZE];
                    end
                    3'b010:  lane_we = 1'b1;
                    default: lane_we = 1'b0;
                endcase
                lane_we = lane_we && st_ok;
                byp_d   = lane_we && (w_row == r_row);
            end

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[w_row] <= wbyte;
                end
                if (ld_take) begin
                    rd_q    <= mem[r_row];
                    byp_q   <= byp_d;
                    wbyte_q <= wbyte;
                end
            end

            assign lane_word[gi*BYTE_SIZE +: BYTE_SIZE] = byp_q ? wbyte_q : rd_q;
        end
    endgenerate

    always_comb begin
        read_valid_d  = bus.read_enable;
        load_fault_d  = bus.read_enable && ld_fault;
        store_fault_d = bus.write_enable && st_fault;
        kill_d        = ld_take ? ld_fault : kill_q;
        funct3_d      = ld_take ? bus.read_funct3 : funct3_q;
        off_d         = ld_take ? bus.read_addr[1:0] : off_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_valid_q  <= 1'b0;
            load_fault_q  <= 1'b0;
            store_fault_q <= 1'b0;
            kill_q        <= 1'b1;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            read_valid_q  <= read_valid_d;
            load_fault_q  <= load_fault_d;
            store_fault_q <= store_fault_d;
            kill_q        <= kill_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    // Extension works only on registered state, so read_data holds between loads.
    always_comb begin
        logic [BYTE_SIZE-1:0]   sel_byte;
        logic [2*BYTE_SIZE-1:0] sel_half;
        sel_byte = lane_word[off_q*BYTE_SIZE +: BYTE_SIZE];
        sel_half = off_q[1] ? lane_word[XLEN-1:2*BYTE_SIZE] : lane_word[2*BYTE_SIZE-1:0];
        case (funct3_q)
            3'b000:  read_data_c = {{(XLEN-BYTE_SIZE){sel_byte[BYTE_SIZE-1]}}, sel_byte};
            3'b100:  read_data_c = {{(XLEN-BYTE_SIZE){1'b0}}, sel_byte};
            3'b001:  read_data_c = {{(XLEN-2*BYTE_SIZE){sel_half[2*BYTE_SIZE-1]}}, sel_half};
            3'b101:  read_data_c = {{(XLEN-2*BYTE_SIZE){1'b0}}, sel_half};
            default: read_data_c = lane_word;
        endcase
        if (kill_q) begin
            read_data_c = '0;
        end
    end

    assign bus.read_data   = read_data_c;
    assign bus.read_valid  = read_valid_q;
    assign bus.load_fault  = load_fault_q;
    assign bus.store_fault = store_fault_q;
endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: directed vector table, reset sequence,
// and randomized traffic checked against a byte-array reference model.
module tb_data_memory_sync;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_sync_if #(.XLEN(32)) bus_if ();

    data_memory_sync #(.XLEN(32), .BYTE_SIZE(8), .DEPTH_BYTES(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [0:DEPTH-1];
    logic        m_v, m_lf, m_sf;
    logic [31:0] m_d;

    typedef struct {
        logic        re;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic        we;
        logic [2:0]  wf;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] ed;
        logic        elf;
        logic        esf;
    } vec_t;
    vec_t tab[$];

    function automatic int msize(input bit is_load, input logic [2:0] f);
        if (is_load) begin
            case (f)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (f)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit mfault(input bit is_load, input logic [2:0] f, input logic [31:0] a);
        int s;
        logic [63:0] last;
        s = msize(is_load, f);
        if (s == 0) return 1'b1;
        if ((a % s) != 0) return 1'b1;
        last = {32'd0, a} + 64'(s) - 64'd1;
        return last >= 64'(DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Drive one cycle, advance the model (stores land before the load is evaluated,
    // which gives write-first semantics), then sample outputs 1 time unit after the edge.
    task automatic step(input bit r, input bit re, input logic [2:0] rf, input logic [31:0] ra,
                        input bit we, input logic [2:0] wf, input logic [31:0] wa,
                        input logic [31:0] wd);
        int s;
        logic [31:0] v;
        rst                 = r;
        bus_if.read_enable  = re;
        bus_if.read_funct3  = rf;
        bus_if.read_addr    = ra;
        bus_if.write_enable = we;
        bus_if.write_funct3 = wf;
        bus_if.write_addr   = wa;
        bus_if.write_data   = wd;
        if (r) begin
            m_v = 1'b0; m_lf = 1'b0; m_sf = 1'b0; m_d = 32'd0;
        end else begin
            m_sf = we && mfault(1'b0, wf, wa);
            if (we && !m_sf) begin
                s = msize(1'b0, wf);
                for (int k = 0; k < s; k++) ref_mem[int'(wa) + k] = wd[8*k +: 8];
            end
            m_v  = re;
            m_lf = re && mfault(1'b1, rf, ra);
            if (re) begin
                if (m_lf) begin
                    m_d = 32'd0;
                end else begin
                    s = msize(1'b1, rf);
                    v = 32'd0;
                    for (int k = 0; k < s; k++) v[8*k +: 8] = ref_mem[int'(ra) + k];
                    if (rf == 3'd0) v = {{24{v[7]}}, v[7:0]};
                    if (rf == 3'd1) v = {{16{v[15]}}, v[15:0]};
                    m_d = v;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " read_valid"},  {31'd0, bus_if.read_valid},  {31'd0, m_v});
        chk({tag, " read_data"},   bus_if.read_data,            m_d);
        chk({tag, " load_fault"},  {31'd0, bus_if.load_fault},  {31'd0, m_lf});
        chk({tag, " store_fault"}, {31'd0, bus_if.store_fault}, {31'd0, m_sf});
    endtask

    initial begin
        logic [2:0]  legal_ld [5];
        logic        r, re, we;
        logic [2:0]  rf, wf;
        logic [31:0] ra, wa;
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bus_if.read_enable = 1'b1; bus_if.read_funct3 = 3'd2; bus_if.read_addr = 32'h10;
        bus_if.write_enable = 1'b0; bus_if.write_funct3 = 3'd2; bus_if.write_addr = 32'h0;
        bus_if.write_data = 32'h0;

        // Reset held two cycles with a load pending, then an idle cycle.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 3'd2, 32'h10, 1'b1, 3'd2, 32'h10, 32'h12345678);
            chk($sformatf("reset%0d read_valid", i), {31'd0, bus_if.read_valid}, 32'd0);
            chk($sformatf("reset%0d read_data", i), bus_if.read_data, 32'd0);
            chk($sformatf("reset%0d load_fault", i), {31'd0, bus_if.load_fault}, 32'd0);
            chk($sformatf("reset%0d store_fault", i), {31'd0, bus_if.store_fault}, 32'd0);
        end
        step(1'b0, 1'b0, 3'd2, 32'h10, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("post_reset read_valid", {31'd0, bus_if.read_valid}, 32'd0);
        chk("post_reset read_data", bus_if.read_data, 32'd0);

        // Fill the whole array so the model knows every byte.
        for (int w = 0; w < DEPTH / 4; w++)
            step(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'(w * 4), $urandom);
        chk("fill store_fault", {31'd0, bus_if.store_fault}, 32'd0);

        //                 re rf    ra            we wf    wa            wd             ev ed            lf sf
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd2,32'h10,       32'hDEADBEEF, 1'b0,32'h0,        1'b0,1'b0});
        tab.push_back('{1'b1,3'd2,32'h10,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'hDEADBEEF, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd4,32'h13,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h000000DE, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd0,32'h13,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'hFFFFFFDE, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd1,32'h12,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'hFFFFDEAD, 1'b0,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd0,32'h11,       32'h00000055, 1'b0,32'hFFFFDEAD, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd2,32'h10,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'hDEAD55EF, 1'b0,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd1,32'h12,       32'h00001234, 1'b0,32'hDEAD55EF, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd5,32'h12,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h00001234, 1'b0,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd2,32'h20,       32'h00000000, 1'b0,32'h00001234, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd2,32'h20,       1'b1,3'd2,32'h20,       32'hCAFEF00D, 1'b1,32'hCAFEF00D, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd2,32'h20,       1'b1,3'd0,32'h21,       32'h000000AA, 1'b1,32'hCAFEAA0D, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd2,32'h20,       1'b1,3'd2,32'h22,       32'h11111111, 1'b1,32'hCAFEAA0D, 1'b0,1'b1});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd1,32'h23,       32'h00002222, 1'b0,32'hCAFEAA0D, 1'b0,1'b1});
        tab.push_back('{1'b1,3'd2,32'h21,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h00000000, 1'b1,1'b0});
        tab.push_back('{1'b1,3'd2,32'h20,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'hCAFEAA0D, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd1,32'h23,       1'b1,3'd2,32'h21,       32'h33333333, 1'b1,32'h00000000, 1'b1,1'b1});
        tab.push_back('{1'b1,3'd2,32'h1000,     1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h00000000, 1'b1,1'b0});
        tab.push_back('{1'b1,3'd2,32'hFFC,      1'b1,3'd2,32'hFFC,      32'h0BADC0DE, 1'b1,32'h0BADC0DE, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd4,32'hFFF,      1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h0000000B, 1'b0,1'b0});
        tab.push_back('{1'b1,3'd3,32'h20,       1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h00000000, 1'b1,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd2,32'h0,        32'h600DCAFE, 1'b0,32'h00000000, 1'b0,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd2,32'h80000000, 32'h12345678, 1'b0,32'h00000000, 1'b0,1'b1});
        tab.push_back('{1'b1,3'd2,32'h0,        1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h600DCAFE, 1'b0,1'b0});
        tab.push_back('{1'b0,3'd0,32'h0,        1'b1,3'd3,32'h24,       32'h44444444, 1'b0,32'h600DCAFE, 1'b0,1'b1});
        tab.push_back('{1'b1,3'd0,32'h1000,     1'b0,3'd0,32'h0,        32'h0,        1'b1,32'h00000000, 1'b1,1'b0});

        foreach (tab[i]) begin
            step(1'b0, tab[i].re, tab[i].rf, tab[i].ra, tab[i].we, tab[i].wf, tab[i].wa, tab[i].wd);
            chk($sformatf("vec%0d read_valid", i),  {31'd0, bus_if.read_valid},  {31'd0, tab[i].ev});
            chk($sformatf("vec%0d read_data", i),   bus_if.read_data,            tab[i].ed);
            chk($sformatf("vec%0d load_fault", i),  {31'd0, bus_if.load_fault},  {31'd0, tab[i].elf});
            chk($sformatf("vec%0d store_fault", i), {31'd0, bus_if.store_fault}, {31'd0, tab[i].esf});
        end

        // Mid-stream reset: a completed load followed by reset clears the held data.
        step(1'b0, 1'b1, 3'd2, 32'h10, 1'b0, 3'd0, 32'h0, 32'h0);
        chk_model("pre_rst");
        step(1'b1, 1'b1, 3'd2, 32'h10, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF);
        chk_model("mid_rst");
        step(1'b0, 1'b1, 3'd2, 32'h10, 1'b0, 3'd0, 32'h0, 32'h0);
        chk_model("after_rst");

        // Random traffic clustered on a small window so loads and stores collide often.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            re = $urandom_range(0, 1) == 1;
            we = $urandom_range(0, 1) == 1;
            rf = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_ld[$urandom_range(0, 4)];
            wf = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            ra = 32'h100 + 32'($urandom_range(0, 15));
            wa = 32'h100 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) ra = 32'(DEPTH - 4 + $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) wa = 32'(DEPTH - 4 + $urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) wa = $urandom;
            step(r, re, rf, ra, we, wf, wa, $urandom);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
